axi4_bitmap_slave: RTL and testbench
====================================

// Module: axi4_bitmap_slave
// PURPOSE
//  AXI4 full-protocol slave fronting a word-addressed bitmap RAM; single ACLK domain.
//  Sits between the PS/interconnect master and the display pipeline.
//  The host writes and reads pixels via AXI bursts; the display engine reads through a side port.
//  Write and read channels are independent FSMs sharing one dual-port RAM.
// PARAMETERS
//  MEM_AWIDTH  10  RAM word-address bits (1024 x 32b = 4 KiB); AXI addr[MEM_AWIDTH+1:2] indexes RAM
//  C_ID_WIDTH  1   AXI ID width
// PORTS
//  ACLK           in   1   sole clock, all logic rising-edge
//  ARESET         in   1   reset, synchronous, active-high
//  S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  1/32/8/3/2  write address info
//  S_AXI_AWLOCK/CACHE/PROT/REGION/QOS/USER in  2/4/3/4/4/1 accepted, ignored
//  S_AXI_AWVALID in 1, S_AXI_AWREADY out 1
//  S_AXI_WID in 1, S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WLAST in 1, S_AXI_WUSER in 1 (ignored)
//  S_AXI_WVALID in 1, S_AXI_WREADY out 1
//  S_AXI_BID out 1, S_AXI_BRESP out 2, S_AXI_BUSER out 1 (tied 0), S_AXI_BVALID out 1, S_AXI_BREADY in 1
//  S_AXI_AR* in   same widths as AW*; S_AXI_ARVALID in 1, S_AXI_ARREADY out 1
//  S_AXI_RID out 1, S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RLAST out 1, S_AXI_RUSER out 1 (tied 0)
//  S_AXI_RVALID out 1, S_AXI_RREADY in 1
//  disp_addr      in   MEM_AWIDTH  display word address
//  disp_data      out  32          mem[disp_addr], registered, 1-cycle latency
// BEHAVIOUR
//  Reset: AWREADY=WREADY=BVALID=ARREADY=RVALID=RLAST=0; BID=RID=0; BRESP=RRESP=0; RDATA=0.
//   RAM contents are not cleared. Reset mid-burst aborts the burst with no response.
//  Write FSM IDLE->WDATA->WRESP->IDLE:
//   IDLE: AWREADY=1 (from first cycle after reset). On AWVALID: latch addr, id, len, burst; AWREADY=0.
//   WDATA: WREADY=1. Each WVALID beat writes RAM with per-byte WSTRB enables.
//    Address steps +4 for INCR/WRAP (WRAP treated as INCR) and holds for FIXED.
//    Beat counter 0..AWLEN; the beat with count==AWLEN ends the burst -> WRESP, WREADY=0.
//   WRESP: BVALID=1, BID=latched id. BRESP=OKAY, or SLVERR if WLAST disagreed with the counter on any beat.
//    Hold until BREADY, then IDLE.
//   A second AWVALID during a burst stalls (AWREADY=0) until return to IDLE; no address queueing.
//  Read FSM IDLE->FETCH->DATA->(FETCH|IDLE):
//   IDLE: ARREADY=1. On ARVALID: latch addr, id, len, burst; ARREADY=0.
//   FETCH: RAM read, 1 cycle. DATA: RVALID=1, RDATA=word, RID=latched id, RRESP=OKAY, RLAST=(count==ARLEN).
//    RVALID/RDATA/RLAST hold stable until RREADY. Then step addr as for writes.
//    If more beats: FETCH, giving one idle cycle between beats. Else: IDLE.
//   First RVALID is 2 cycles after the AR handshake.
//  Channels run concurrently. Same-cycle AXI write and read/display read of one word returns old data.
//  AWSIZE/ARSIZE ignored: always 32-bit beats. Address bits above MEM_AWIDTH+1 alias.
//  Unaligned addr[1:0] is ignored.
// STRUCTURE
//  axi4_pkg: ASIZE_BT_1/2/4=0/1/2, ABURST_FIXED/INCR/WRAP=0/1/2,
//   RESP_OKAY/EXOKAY/SLVERR/DECERR=0..3, FSM state enums.
//  One sub-module bitmap_dp_ram: port A = AXI read/write with byte enables, registered read;
//   port B = display read-only, registered.
// TESTING
//  Reset 100 ns, then AWREADY=ARREADY=1, all valids 0.
//  Write 0x100, LEN=4, INCR, data 0x12345678..0x1234567C, WSTRB=F
//   -> 5 WREADY beats; BVALID with BID=0, BRESP=OKAY.
//   Then read 0x100 LEN=4 -> same 5 words, RLAST on beat 5 only.
//  Write 0x200 LEN=0 data 0x11223344 with ID=1 -> BID=1, OKAY.
//   Read 0x200 -> RDATA=0x11223344, RLAST=1 on the single beat.
//  AW 0x300 then AW 0x400 back-to-back: second AW stalls until B of the first completes.
//   W 0x11112222 lands at 0x300. Re-issue AW 0x400 + W 0x33334444 -> 0x400 holds 0x33334444.
//  Write WSTRB=4'b0011 data 0xAAAABBBB over 0x12345678
//   -> read returns 0x1234BBBB, and disp_data at that word matches 1 cycle after disp_addr.
//  RREADY low 5 cycles mid-burst -> RDATA/RLAST/RVALID stable. Concurrent write+read bursts both complete correctly.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings, datapath widths and FSM state codes for the bitmap slave.
package axi4_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [2:0] ASIZE_BT_1 = 3'd0;
    localparam logic [2:0] ASIZE_BT_2 = 3'd1;
    localparam logic [2:0] ASIZE_BT_4 = 3'd2;

    localparam logic [1:0] ABURST_FIXED = 2'd0;
    localparam logic [1:0] ABURST_INCR  = 2'd1;
    localparam logic [1:0] ABURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    localparam logic [1:0] WR_IDLE = 2'd0;
    localparam logic [1:0] WR_DATA = 2'd1;
    localparam logic [1:0] WR_RESP = 2'd2;

    localparam logic [1:0] RD_IDLE  = 2'd0;
    localparam logic [1:0] RD_FETCH = 2'd1;
    localparam logic [1:0] RD_DATA  = 2'd2;

    // WRAP bursts are walked like INCR; only FIXED keeps the address.
    function automatic logic burst_advances(input logic [1:0] burst);
        return burst != ABURST_FIXED;
    endfunction

endpackage

// File: rtl/bitmap_dp_ram.sv
// Word-addressed bitmap RAM: port A byte-enabled write plus registered read, port B registered display read.
module bitmap_dp_ram
    import axi4_pkg::*;
#(
    parameter int AWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STRB_W-1:0] a_we,
    input  logic [AWIDTH-1:0] a_waddr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_re,
    input  logic [AWIDTH-1:0] a_raddr,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [AWIDTH-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata
);

    logic [DATA_W-1:0] mem [0:(1<<AWIDTH)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (a_we[i]) mem[a_waddr][8*i +: 8] <= a_wdata[8*i +: 8];
        end
    end

    // Reads sample the array before this edge's write, so a colliding read sees old data.
    always_ff @(posedge clk) begin
        if (rst)       a_rdata <= '0;
        else if (a_re) a_rdata <= mem[a_raddr];
    end

    always_ff @(posedge clk) begin
        b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/axi4_bitmap_slave.sv
// AXI4 slave in front of the bitmap RAM; independent write and read FSMs plus a display read port.
module axi4_bitmap_slave
    import axi4_pkg::*;
#(
    parameter int MEM_AWIDTH = 10,
    parameter int C_ID_WIDTH = 1
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [C_ID_WIDTH-1:0] S_AXI_AWID,
    input  logic [31:0]           S_AXI_AWADDR,
    input  logic [7:0]            S_AXI_AWLEN,
    input  logic [2:0]            S_AXI_AWSIZE,
    input  logic [1:0]            S_AXI_AWBURST,
    input  logic [1:0]            S_AXI_AWLOCK,
    input  logic [3:0]            S_AXI_AWCACHE,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic [3:0]            S_AXI_AWREGION,
    input  logic [3:0]            S_AXI_AWQOS,
    input  logic                  S_AXI_AWUSER,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [C_ID_WIDTH-1:0] S_AXI_WID,
    input  logic [DATA_W-1:0]     S_AXI_WDATA,
    input  logic [STRB_W-1:0]     S_AXI_WSTRB,
    input  logic                  S_AXI_WLAST,
    input  logic                  S_AXI_WUSER,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [C_ID_WIDTH-1:0] S_AXI_BID,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BUSER,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [C_ID_WIDTH-1:0] S_AXI_ARID,
    input  logic [31:0]           S_AXI_ARADDR,
    input  logic [7:0]            S_AXI_ARLEN,
    input  logic [2:0]            S_AXI_ARSIZE,
    input  logic [1:0]            S_AXI_ARBURST,
    input  logic [1:0]            S_AXI_ARLOCK,
    input  logic [3:0]            S_AXI_ARCACHE,
    input  logic [2:0]            S_AXI_ARPROT,
    input  logic [3:0]            S_AXI_ARREGION,
    input  logic [3:0]            S_AXI_ARQOS,
    input  logic                  S_AXI_ARUSER,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [C_ID_WIDTH-1:0] S_AXI_RID,
    output logic [DATA_W-1:0]     S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RLAST,
    output logic                  S_AXI_RUSER,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    input  logic [MEM_AWIDTH-1:0] disp_addr,
    output logic [DATA_W-1:0]     disp_data
);

    logic [1:0]            wr_state, rd_state;
    logic [MEM_AWIDTH-1:0] wr_addr, rd_addr;
    logic [7:0]            wr_len, wr_cnt, rd_len, rd_cnt;
    logic [1:0]            wr_burst, rd_burst;
    logic                  wr_err;
    logic                  aw_hs, w_beat, w_final, w_last_bad, ar_hs, r_beat;
    logic                  unused;

    assign aw_hs      = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_beat     = S_AXI_WVALID && S_AXI_WREADY;
    assign w_final    = wr_cnt == wr_len;
    assign w_last_bad = S_AXI_WLAST != w_final;
    assign ar_hs      = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_beat     = S_AXI_RVALID && S_AXI_RREADY;

    assign S_AXI_BUSER = 1'b0;
    assign S_AXI_RUSER = 1'b0;
    assign S_AXI_RRESP = RESP_OKAY;

    assign unused = &{1'b0, S_AXI_AWADDR[31:MEM_AWIDTH+2], S_AXI_AWADDR[1:0], S_AXI_AWSIZE,
                      S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWREGION, S_AXI_AWQOS,
                      S_AXI_AWUSER, S_AXI_WID, S_AXI_WUSER, S_AXI_ARADDR[31:MEM_AWIDTH+2],
                      S_AXI_ARADDR[1:0], S_AXI_ARSIZE, S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT,
                      S_AXI_ARREGION, S_AXI_ARQOS, S_AXI_ARUSER};

    // Write channel control
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state      <= WR_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BID     <= '0;
            S_AXI_BRESP   <= RESP_OKAY;
            wr_cnt        <= '0;
            wr_err        <= 1'b0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (aw_hs) begin
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                        S_AXI_BID     <= S_AXI_AWID;
                        wr_cnt        <= '0;
                        wr_err        <= 1'b0;
                        wr_state      <= WR_DATA;
                    end else begin
                        S_AXI_AWREADY <= 1'b1;
                    end
                end
                WR_DATA: begin
                    if (w_beat) begin
                        wr_cnt <= wr_cnt + 8'd1;
                        if (w_last_bad) wr_err <= 1'b1;
                        // The beat counter, not WLAST, decides where the burst ends.
                        if (w_final) begin
                            S_AXI_WREADY <= 1'b0;
                            S_AXI_BVALID <= 1'b1;
                            S_AXI_BRESP  <= (wr_err || w_last_bad) ? RESP_SLVERR : RESP_OKAY;
                            wr_state     <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        wr_state      <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (aw_hs) begin
            wr_addr  <= S_AXI_AWADDR[MEM_AWIDTH+1:2];
            wr_len   <= S_AXI_AWLEN;
            wr_burst <= S_AXI_AWBURST;
        end else if (w_beat && burst_advances(wr_burst)) begin
            wr_addr <= wr_addr + MEM_AWIDTH'(1);
        end
    end

    // Read channel control
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state      <= RD_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RLAST   <= 1'b0;
            S_AXI_RID     <= '0;
            rd_cnt        <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RID     <= S_AXI_ARID;
                        rd_cnt        <= '0;
                        rd_state      <= RD_FETCH;
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                RD_FETCH: begin
                    S_AXI_RVALID <= 1'b1;
                    S_AXI_RLAST  <= rd_cnt == rd_len;
                    rd_state     <= RD_DATA;
                end
                RD_DATA: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        S_AXI_RLAST  <= 1'b0;
                        rd_cnt       <= rd_cnt + 8'd1;
                        if (S_AXI_RLAST) begin
                            S_AXI_ARREADY <= 1'b1;
                            rd_state      <= RD_IDLE;
                        end else begin
                            rd_state <= RD_FETCH;
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ar_hs) begin
            rd_addr  <= S_AXI_ARADDR[MEM_AWIDTH+1:2];
            rd_len   <= S_AXI_ARLEN;
            rd_burst <= S_AXI_ARBURST;
        end else if (r_beat && burst_advances(rd_burst)) begin
            rd_addr <= rd_addr + MEM_AWIDTH'(1);
        end
    end

    // RDATA is the RAM output register; it only reloads in FETCH, so it holds through RREADY stalls.
    bitmap_dp_ram #(.AWIDTH(MEM_AWIDTH)) u_ram (
        .clk     (ACLK),
        .rst     (ARESET),
        .a_we    (w_beat ? S_AXI_WSTRB : '0),
        .a_waddr (wr_addr),
        .a_wdata (S_AXI_WDATA),
        .a_re    (rd_state == RD_FETCH),
        .a_raddr (rd_addr),
        .a_rdata (S_AXI_RDATA),
        .b_addr  (disp_addr),
        .b_rdata (disp_data)
    );

endmodule

// File: tb/tb_axi4_bitmap_slave.sv
// Directed bench for axi4_bitmap_slave: bursts, responses, stalls, byte strobes and display port.
module tb_axi4_bitmap_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        S_AXI_AWID, S_AXI_AWUSER, S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic [2:0]  S_AXI_AWSIZE, S_AXI_AWPROT;
    logic [1:0]  S_AXI_AWBURST, S_AXI_AWLOCK;
    logic [3:0]  S_AXI_AWCACHE, S_AXI_AWREGION, S_AXI_AWQOS;
    logic        S_AXI_WID, S_AXI_WLAST, S_AXI_WUSER, S_AXI_WVALID, S_AXI_WREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_BID, S_AXI_BUSER, S_AXI_BVALID, S_AXI_BREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_ARID, S_AXI_ARUSER, S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic [2:0]  S_AXI_ARSIZE, S_AXI_ARPROT;
    logic [1:0]  S_AXI_ARBURST, S_AXI_ARLOCK;
    logic [3:0]  S_AXI_ARCACHE, S_AXI_ARREGION, S_AXI_ARQOS;
    logic        S_AXI_RID, S_AXI_RLAST, S_AXI_RUSER, S_AXI_RVALID, S_AXI_RREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic [9:0]  disp_addr;
    logic [31:0] disp_data;

    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;
    logic [31:0] exp_mem [0:15];

    axi4_bitmap_slave #(.MEM_AWIDTH(10), .C_ID_WIDTH(1)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWLOCK(S_AXI_AWLOCK),
        .S_AXI_AWCACHE(S_AXI_AWCACHE), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWREGION(S_AXI_AWREGION),
        .S_AXI_AWQOS(S_AXI_AWQOS), .S_AXI_AWUSER(S_AXI_AWUSER), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WID(S_AXI_WID), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WLAST(S_AXI_WLAST), .S_AXI_WUSER(S_AXI_WUSER), .S_AXI_WVALID(S_AXI_WVALID),
        .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BUSER(S_AXI_BUSER),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARLOCK(S_AXI_ARLOCK),
        .S_AXI_ARCACHE(S_AXI_ARCACHE), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARREGION(S_AXI_ARREGION),
        .S_AXI_ARQOS(S_AXI_ARQOS), .S_AXI_ARUSER(S_AXI_ARUSER), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RUSER(S_AXI_RUSER), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY),
        .disp_addr(disp_addr), .disp_data(disp_data)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic aw_hs(input logic [31:0] addr, input logic id, input logic [7:0] len,
                         input logic [1:0] burst);
        int n;
        n = 0;
        S_AXI_AWADDR = addr; S_AXI_AWID = id; S_AXI_AWLEN = len; S_AXI_AWBURST = burst;
        S_AXI_AWVALID = 1'b1;
        while (!S_AXI_AWREADY && n < 50) begin tick(); n++; end
        check("aw_ready", 32'(S_AXI_AWREADY), 32'd1);
        tick();
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic w_beats(input logic [31:0] base, input logic [7:0] len, input logic [3:0] strb,
                           input logic bad_last);
        int n;
        int l;
        l = int'(len);
        for (int i = 0; i <= l; i++) begin
            n = 0;
            S_AXI_WDATA = base + 32'(i); S_AXI_WSTRB = strb;
            S_AXI_WLAST = bad_last ? (i == 0) : (i == l);
            S_AXI_WVALID = 1'b1;
            while (!S_AXI_WREADY && n < 50) begin tick(); n++; end
            check("w_ready", 32'(S_AXI_WREADY), 32'd1);
            tick();
        end
        S_AXI_WVALID = 1'b0;
        S_AXI_WLAST  = 1'b0;
        check("w_ready_drop", 32'(S_AXI_WREADY), 32'd0);
    endtask

    task automatic b_resp(input logic id, input logic [1:0] resp);
        int n;
        n = 0;
        S_AXI_BREADY = 1'b1;
        while (!S_AXI_BVALID && n < 50) begin tick(); n++; end
        check("b_valid", 32'(S_AXI_BVALID), 32'd1);
        check("b_id", 32'(S_AXI_BID), 32'(id));
        check("b_resp", 32'(S_AXI_BRESP), 32'(resp));
        tick();
        S_AXI_BREADY = 1'b0;
        check("b_valid_clear", 32'(S_AXI_BVALID), 32'd0);
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic id, input logic [7:0] len,
                               input logic [1:0] burst, input logic [31:0] base,
                               input logic [3:0] strb, input logic bad_last, input logic [1:0] resp);
        aw_hs(addr, id, len, burst);
        w_beats(base, len, strb, bad_last);
        b_resp(id, resp);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic id, input logic [7:0] len,
                              input logic [1:0] burst, input int stall_beat);
        int n;
        int l;
        l = int'(len);
        n = 0;
        S_AXI_ARADDR = addr; S_AXI_ARID = id; S_AXI_ARLEN = len; S_AXI_ARBURST = burst;
        S_AXI_ARVALID = 1'b1;
        while (!S_AXI_ARREADY && n < 50) begin tick(); n++; end
        check("ar_ready", 32'(S_AXI_ARREADY), 32'd1);
        tick();
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b1;
        for (int i = 0; i <= l; i++) begin
            n = 0;
            while (!S_AXI_RVALID && n < 50) begin tick(); n++; end
            check("r_valid", 32'(S_AXI_RVALID), 32'd1);
            if (i == 0) check("r_first_latency", 32'(n), 32'd1);
            check("r_data", S_AXI_RDATA, exp_mem[i]);
            check("r_last", 32'(S_AXI_RLAST), 32'(i == l));
            check("r_id", 32'(S_AXI_RID), 32'(id));
            check("r_resp", 32'(S_AXI_RRESP), 32'd0);
            if (i == stall_beat) begin
                S_AXI_RREADY = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    check("r_stall_valid", 32'(S_AXI_RVALID), 32'd1);
                    check("r_stall_data", S_AXI_RDATA, exp_mem[i]);
                    check("r_stall_last", 32'(S_AXI_RLAST), 32'(i == l));
                end
                S_AXI_RREADY = 1'b1;
            end
            tick();
            check("r_valid_gap", 32'(S_AXI_RVALID), 32'd0);
        end
        S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ARESET = 1'b1;
        S_AXI_AWID = 1'b0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = 3'd2;
        S_AXI_AWBURST = 2'd1; S_AXI_AWLOCK = '0; S_AXI_AWCACHE = '0; S_AXI_AWPROT = '0;
        S_AXI_AWREGION = '0; S_AXI_AWQOS = '0; S_AXI_AWUSER = 1'b0; S_AXI_AWVALID = 1'b0;
        S_AXI_WID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0;
        S_AXI_WUSER = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARID = 1'b0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = 3'd2;
        S_AXI_ARBURST = 2'd1; S_AXI_ARLOCK = '0; S_AXI_ARCACHE = '0; S_AXI_ARPROT = '0;
        S_AXI_ARREGION = '0; S_AXI_ARQOS = '0; S_AXI_ARUSER = 1'b0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0; disp_addr = '0;

        // Reset values
        #96;
        check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        check("rst_wready", 32'(S_AXI_WREADY), 32'd0);
        check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        check("rst_rlast", 32'(S_AXI_RLAST), 32'd0);
        check("rst_rdata", S_AXI_RDATA, 32'd0);
        check("rst_ids", {30'd0, S_AXI_BID, S_AXI_RID}, 32'd0);
        check("rst_resps", {28'd0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
        check("rst_users", {30'd0, S_AXI_BUSER, S_AXI_RUSER}, 32'd0);
        #4;
        ARESET = 1'b0;
        tick();
        check("idle_awready", 32'(S_AXI_AWREADY), 32'd1);
        check("idle_arready", 32'(S_AXI_ARREADY), 32'd1);

        // 5-beat INCR write, read back with a 5-cycle RREADY stall on beat 2
        write_burst(32'h100, 1'b0, 8'd4, 2'd1, 32'h12345678, 4'hF, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) exp_mem[i] = 32'h12345678 + 32'(i);
        read_burst(32'h100, 1'b0, 8'd4, 2'd1, 2);

        // Single beat with ID=1
        write_burst(32'h200, 1'b1, 8'd0, 2'd1, 32'h11223344, 4'hF, 1'b0, 2'd0);
        exp_mem[0] = 32'h11223344;
        read_burst(32'h200, 1'b1, 8'd0, 2'd1, -1);

        // Second AW stalls until the first burst's B handshake
        aw_hs(32'h300, 1'b0, 8'd0, 2'd1);
        S_AXI_AWADDR = 32'h400; S_AXI_AWVALID = 1'b1;
        check("aw_stall_data", 32'(S_AXI_AWREADY), 32'd0);
        w_beats(32'h11112222, 8'd0, 4'hF, 1'b0);
        check("aw_stall_resp", 32'(S_AXI_AWREADY), 32'd0);
        b_resp(1'b0, 2'd0);
        aw_hs(32'h400, 1'b0, 8'd0, 2'd1);
        w_beats(32'h33334444, 8'd0, 4'hF, 1'b0);
        b_resp(1'b0, 2'd0);
        exp_mem[0] = 32'h11112222;
        read_burst(32'h300, 1'b0, 8'd0, 2'd1, -1);
        exp_mem[0] = 32'h33334444;
        read_burst(32'h400, 1'b0, 8'd0, 2'd1, -1);

        // Partial strobe merges into the old word; display port sees it too
        write_burst(32'h500, 1'b0, 8'd0, 2'd1, 32'h12345678, 4'hF, 1'b0, 2'd0);
        write_burst(32'h500, 1'b0, 8'd0, 2'd1, 32'hAAAABBBB, 4'b0011, 1'b0, 2'd0);
        exp_mem[0] = 32'h1234BBBB;
        read_burst(32'h500, 1'b0, 8'd0, 2'd1, -1);
        disp_addr = 10'h140;
        tick();
        check("disp_strb_word", disp_data, 32'h1234BBBB);
        disp_addr = 10'h041;
        tick();
        check("disp_burst_word", disp_data, 32'h12345679);

        // WLAST on the wrong beats gives SLVERR
        write_burst(32'h600, 1'b1, 8'd1, 2'd1, 32'h600A0000, 4'hF, 1'b1, 2'd2);

        // FIXED burst keeps overwriting one word
        write_burst(32'h700, 1'b0, 8'd2, 2'd0, 32'h70000000, 4'hF, 1'b0, 2'd0);
        exp_mem[0] = 32'h70000002; exp_mem[1] = 32'h70000002;
        read_burst(32'h700, 1'b0, 8'd1, 2'd0, -1);

        // Upper address bits alias onto the same RAM
        exp_mem[0] = 32'h12345678;
        read_burst(32'h0010_0100, 1'b0, 8'd0, 2'd1, -1);

        // Concurrent write and read bursts
        for (int i = 0; i < 5; i++) exp_mem[i] = 32'h12345678 + 32'(i);
        fork
            write_burst(32'h800, 1'b1, 8'd3, 2'd1, 32'h80000000, 4'hF, 1'b0, 2'd0);
            read_burst(32'h100, 1'b0, 8'd4, 2'd1, -1);
        join
        for (int i = 0; i < 4; i++) exp_mem[i] = 32'h80000000 + 32'(i);
        read_burst(32'h800, 1'b1, 8'd3, 2'd1, -1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
